// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, hex-digit conversion and the
// frame-engine state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_START = 2'd1;
  localparam logic [1:0] F_DATA  = 2'd2;
  localparam logic [1:0] F_STOP  = 2'd3;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'd0, n};
    else           return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 frame engine. The accept cycle already drives the start bit, so a new
// frame can follow a stop bit with no idle gap.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_r;
  logic             last_cnt;

  assign last_cnt = (clk_cnt == CNT_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= F_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        F_IDLE: begin
          // The accept cycle is the first start-bit cycle.
          if (i_TX_DV) begin
            state   <= F_START;
            clk_cnt <= CNT_W'(1);
            bit_idx <= '0;
          end
        end
        F_START: begin
          if (last_cnt) begin
            state   <= F_DATA;
            clk_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        F_DATA: begin
          if (last_cnt) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= F_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          if (last_cnt) begin
            state   <= F_IDLE;
            clk_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (state == F_IDLE && i_TX_DV) data_r <= i_TX_Byte;
  end

  always_comb begin
    o_TX_Serial = 1'b1;
    case (state)
      F_IDLE:  o_TX_Serial = ~i_TX_DV;
      F_START: o_TX_Serial = 1'b0;
      F_DATA:  o_TX_Serial = data_r[bit_idx];
      default: o_TX_Serial = 1'b1;
    endcase
  end

  assign o_TX_Active = (state != F_IDLE);
  assign o_TX_Done   = (state == F_STOP) && last_cnt;

endmodule

// File: rtl/byte_hex_uart_tx.sv
// Sends one byte as two uppercase ASCII hex characters (optionally + CR LF)
// over an 8N1 UART line.
module byte_hex_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SEND_CRLF    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_UART_TX
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [1:0] LAST_IDX = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

  logic [1:0] state;
  logic [1:0] char_idx;
  logic [7:0] byte_r;
  logic [7:0] tx_char;
  logic       tx_dv;
  logic       tx_active;
  logic       tx_done;
  logic       can_accept;

  // FINISH counts as idle so back-to-back messages need no extra cycle.
  assign can_accept = (state == S_IDLE) || (state == S_FINISH);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      char_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH: begin
          if (i_DV) begin
            state    <= S_LOAD;
            char_idx <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: state <= S_SEND;
        default: begin
          if (tx_done) begin
            char_idx <= char_idx + 1'b1;
            state    <= (char_idx == LAST_IDX) ? S_FINISH : S_LOAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (can_accept && i_DV && !i_Reset) byte_r <= i_Byte;
  end

  always_comb begin
    tx_char = ASCII_LF;
    case (char_idx)
      2'd0:    tx_char = nibble_to_ascii(byte_r[7:4]);
      2'd1:    tx_char = nibble_to_ascii(byte_r[3:0]);
      2'd2:    tx_char = ASCII_CR;
      default: tx_char = ASCII_LF;
    endcase
  end

  assign tx_dv = (state == S_LOAD);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_char),
    .o_TX_Serial(o_UART_TX),
    .o_TX_Active(tx_active),
    .o_TX_Done  (tx_done)
  );

  assign o_Busy = tx_dv | tx_active;
  assign o_Done = (state == S_FINISH);

endmodule

// File: tb/tb_byte_hex_uart_tx.sv
// Directed bench for byte_hex_uart_tx: a fast CRLF instance (4 clocks/bit)
// and a full-rate hex-only instance (104 clocks/bit).
module tb_byte_hex_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] byt;
  logic       sel;

  logic dv_a, busy_a, done_a, tx_a;
  logic dv_b, busy_b, done_b, tx_b;

  assign dv_a = sel ? 1'b0 : dv;
  assign dv_b = sel ? dv : 1'b0;

  byte_hex_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(1)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_DV(dv_a), .i_Byte(byt),
    .o_Busy(busy_a), .o_Done(done_a), .o_UART_TX(tx_a)
  );

  byte_hex_uart_tx #(.CLKS_PER_BIT(104), .SEND_CRLF(0)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_DV(dv_b), .i_Byte(byt),
    .o_Busy(busy_b), .o_Done(done_b), .o_UART_TX(tx_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic ln [0:2199];
  logic bz [0:2199];
  logic dn [0:2199];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte for the accept cycle N; returns just after that edge.
  task automatic send(input logic [7:0] b);
    byt = b;
    dv  = 1'b1;
    @(posedge clk);
  endtask

  // Record cycles N+1..N+len at the falling edge. i_DV is high for
  // j in [on_s, on_e) carrying inj; i_Reset is high at j == rst_at.
  task automatic capture(input int len, input int on_s, input int on_e,
                         input logic [7:0] inj, input int rst_at);
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      dv  = (j >= on_s) && (j < on_e);
      if (dv) byt = inj;
      rst = (j == rst_at);
      ln[j] = sel ? tx_b   : tx_a;
      bz[j] = sel ? busy_b : busy_a;
      dn[j] = sel ? done_b : done_a;
    end
    dv  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic decode_char(input string tag, input int base, input int k,
                             input int c, input logic [7:0] exp);
    int off;
    logic [7:0] d;
    off = base + 1 + k * 10 * c;
    check({tag, "_start"}, 32'(ln[off + c/2]), 32'd0);
    for (int b = 0; b < 8; b++) d[b] = ln[off + (b + 1) * c + c/2];
    check({tag, "_data"}, 32'(d), 32'(exp));
    check({tag, "_stop"}, 32'(ln[off + 9 * c + c/2]), 32'd1);
  endtask

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (dn[j]) n++;
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (bz[j]) n++;
    return n;
  endfunction

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    dv  = 1'b0;
    byt = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_a",   32'(tx_a),   32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_tx_b",   32'(tx_b),   32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x5A -> "5A\r\n"
    send(8'h5A);
    capture(170, 0, 0, 8'h00, 0);
    check("t1_first_start", 32'(ln[1]), 32'd0);
    check("t1_first_busy",  32'(bz[1]), 32'd1);
    decode_char("t1_c0", 0, 0, 4, 8'h35);
    decode_char("t1_c1", 0, 1, 4, 8'h41);
    decode_char("t1_c2", 0, 2, 4, 8'h0D);
    decode_char("t1_c3", 0, 3, 4, 8'h0A);
    check("t1_busy_cnt",  32'(count_busy(1, 170)), 32'd160);
    check("t1_busy_last", 32'(bz[160]), 32'd1);
    check("t1_done_pos",  32'(dn[161]), 32'd1);
    check("t1_busy_done", 32'(bz[161]), 32'd0);
    check("t1_done_cnt",  32'(count_done(1, 170)), 32'd1);

    // 0x00, 0xFF, then the 9/A boundary with 0x9A
    send(8'h00);
    capture(170, 0, 0, 8'h00, 0);
    decode_char("t2a_c0", 0, 0, 4, 8'h30);
    decode_char("t2a_c1", 0, 1, 4, 8'h30);
    decode_char("t2a_c3", 0, 3, 4, 8'h0A);
    send(8'hFF);
    capture(170, 0, 0, 8'h00, 0);
    decode_char("t2b_c0", 0, 0, 4, 8'h46);
    decode_char("t2b_c1", 0, 1, 4, 8'h46);
    decode_char("t2b_c2", 0, 2, 4, 8'h0D);
    send(8'h9A);
    capture(170, 0, 0, 8'h00, 0);
    decode_char("t2c_c0", 0, 0, 4, 8'h39);
    decode_char("t2c_c1", 0, 1, 4, 8'h41);

    // i_DV mid-message is ignored
    send(8'h34);
    capture(200, 50, 51, 8'h12, 0);
    decode_char("t3_c0", 0, 0, 4, 8'h33);
    decode_char("t3_c1", 0, 1, 4, 8'h34);
    decode_char("t3_c2", 0, 2, 4, 8'h0D);
    decode_char("t3_c3", 0, 3, 4, 8'h0A);
    check("t3_done_cnt", 32'(count_done(1, 200)), 32'd1);
    check("t3_idle_busy", 32'(count_busy(162, 200)), 32'd0);
    check("t3_idle_line", 32'(ln[190]), 32'd1);

    // i_DV held through o_Done: back-to-back messages
    send(8'h21);
    capture(330, 1, 162, 8'hC3, 0);
    decode_char("t4a_c0", 0, 0, 4, 8'h32);
    decode_char("t4a_c1", 0, 1, 4, 8'h31);
    check("t4_done1",  32'(dn[161]), 32'd1);
    check("t4_start2", 32'(ln[162]), 32'd0);
    check("t4_busy2",  32'(bz[162]), 32'd1);
    decode_char("t4b_c0", 161, 0, 4, 8'h43);
    decode_char("t4b_c1", 161, 1, 4, 8'h33);
    decode_char("t4b_c3", 161, 3, 4, 8'h0A);
    check("t4_done2",    32'(dn[322]), 32'd1);
    check("t4_done_cnt", 32'(count_done(1, 330)), 32'd2);

    // Reset mid data bit of C1
    send(8'h5A);
    capture(200, 0, 0, 8'h00, 57);
    check("t5_pre_busy",  32'(bz[57]), 32'd1);
    check("t5_line_rst",  32'(ln[58]), 32'd1);
    check("t5_busy_rst",  32'(bz[58]), 32'd0);
    check("t5_no_done",   32'(count_done(1, 200)), 32'd0);
    check("t5_busy_after", 32'(count_busy(58, 200)), 32'd0);
    send(8'h7E);
    capture(170, 0, 0, 8'h00, 0);
    decode_char("t5_c0", 0, 0, 4, 8'h37);
    decode_char("t5_c1", 0, 1, 4, 8'h45);
    decode_char("t5_c2", 0, 2, 4, 8'h0D);
    decode_char("t5_c3", 0, 3, 4, 8'h0A);
    check("t5_done_pos", 32'(dn[161]), 32'd1);

    // Hex only at full rate
    sel = 1'b1;
    @(negedge clk);
    send(8'hB6);
    capture(2090, 0, 0, 8'h00, 0);
    decode_char("t6_c0", 0, 0, 104, 8'h42);
    decode_char("t6_c1", 0, 1, 104, 8'h36);
    check("t6_busy_cnt",  32'(count_busy(1, 2090)), 32'd2080);
    check("t6_busy_last", 32'(bz[2080]), 32'd1);
    check("t6_done_pos",  32'(dn[2081]), 32'd1);
    check("t6_done_cnt",  32'(count_done(1, 2090)), 32'd1);
    check("t6_idle_line", 32'(ln[2085]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
